// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: feeds one operand bit pair plus the running
// carry into a single full-adder cell per clock and assembles the result.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    input  logic             CIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM_OUT,
    output logic             COUT
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             cout_q, cout_d;

    logic bit_sum;
    logic bit_carry;

    // Full-adder cell operating on the low bits of the shift registers.
    assign bit_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign bit_carry = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    // Next-state and datapath logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path can
        // leave it unassigned, which would infer a latch.
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        s_sh_d    = s_sh_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_out_d = sum_out_q;
        cout_d    = cout_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = A_IN;
                    b_sh_d  = B_IN;
                    carry_d = CIN;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                s_sh_d  = {bit_sum, s_sh_q[WIDTH-1:1]};
                carry_d = bit_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the completed result in one step so
                    // partial sums never reach the outputs.
                    sum_out_d = {bit_sum, s_sh_q[WIDTH-1:1]};
                    cout_d    = bit_carry;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, because an aborted
        // operation must return the result outputs to zero.
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            s_sh_q    <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            s_sh_q    <= s_sh_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sum_out_q <= sum_out_d;
            cout_q    <= cout_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign SUM_OUT = sum_out_q;
    assign COUT    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 (dut 0) and WIDTH=13
// (dut 1). Accepted starts push the arithmetic result into a queue; a
// monitor on the falling edge pops and compares when done is presented.
module tb_serial_adder_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        start [2];
    logic [12:0] a_in  [2];
    logic [12:0] b_in  [2];
    logic        cin   [2];

    logic        busy0, done0, cout0;
    logic [7:0]  sum0;
    logic        busy1, done1, cout1;
    logic [12:0] sum1;

    serial_adder_ctrl #(.WIDTH(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .A_IN(a_in[0][7:0]), .B_IN(b_in[0][7:0]), .CIN(cin[0]),
        .busy(busy0), .done(done0), .SUM_OUT(sum0), .COUT(cout0)
    );

    serial_adder_ctrl #(.WIDTH(13)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .A_IN(a_in[1]), .B_IN(b_in[1]), .CIN(cin[1]),
        .busy(busy1), .done(done1), .SUM_OUT(sum1), .COUT(cout1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] res;
        int          c0;
    } exp_t;

    typedef struct {
        int          kind;  // 0: compare dut0 result, 1: compare op counts
        logic [13:0] exp;
    } dir_t;

    exp_t        q0[$];
    exp_t        q1[$];
    dir_t        dir_q[$];
    int          rem     [2];
    int          acc_cnt [2];
    int          done_cnt[2];
    logic [13:0] last    [2];
    int          cyc;
    int          n_checks;
    int          n_errors;

    function automatic int wid(input int d);
        return (d == 0) ? 8 : 13;
    endfunction

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, d, cyc, act, exp);
        end
    endtask

    // Reference model: an accepted start occupies the unit for WIDTH+1
    // busy cycles and produces A+B+CIN modulo 2^(WIDTH+1).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt[0] -= q0.size();
            acc_cnt[1] -= q1.size();
            q0.delete();
            q1.delete();
            rem[0] = 0;
            rem[1] = 0;
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rem[d] == 0 && start[d]) begin
                    automatic int          w  = wid(d);
                    automatic logic [13:0] am = 14'((1 << w) - 1);
                    automatic logic [13:0] rm = 14'((1 << (w + 1)) - 1);
                    automatic exp_t        e;
                    e.res = ((14'(a_in[d]) & am) + (14'(b_in[d]) & am) + 14'(cin[d])) & rm;
                    e.c0  = cyc;
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                    rem[d] = w + 1;
                    acc_cnt[d]++;
                end else if (rem[d] > 0) begin
                    rem[d]--;
                end
            end
        end
    end

    // Monitor: compare done, result, held outputs and busy each falling edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last[0] = '0;
            last[1] = '0;
        end
        if (!clk) begin
            for (int d = 0; d < 2; d++) begin
                automatic logic        b   = (d == 0) ? busy0 : busy1;
                automatic logic        dn  = (d == 0) ? done0 : done1;
                automatic logic [13:0] res = (d == 0) ? {5'd0, cout0, sum0} : {cout1, sum1};
                automatic int          qs  = (d == 0) ? q0.size() : q1.size();
                automatic exp_t        hd;
                automatic logic        exp_dn;
                if (qs > 0) hd = (d == 0) ? q0[0] : q1[0];
                exp_dn = (qs > 0) && (cyc - hd.c0 == wid(d));
                check("done", d, 32'(dn), 32'(exp_dn));
                if (dn && qs > 0) begin
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                    check("result", d, 32'(res), 32'(hd.res));
                    last[d] = hd.res;
                    done_cnt[d]++;
                end else if (qs > 0 && cyc - hd.c0 >= wid(d)) begin
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
                check("hold", d, 32'(res), 32'(last[d]));
                check("busy", d, 32'(b), 32'(rem[d] != 0));
            end
            while (dir_q.size() > 0) begin
                automatic dir_t r = dir_q.pop_front();
                if (r.kind == 0) begin
                    check("directed_sum", 0, 32'({cout0, sum0}), 32'(r.exp));
                end else begin
                    check("op_count", 0, 32'(done_cnt[0]), 32'(acc_cnt[0]));
                    check("op_count", 1, 32'(done_cnt[1]), 32'(acc_cnt[1]));
                end
            end
        end
    end

    task automatic wait_idle(input int d);
        while (rem[d] != 0) @(negedge clk);
    endtask

    // One start pulse, then scramble the inputs to prove they were captured.
    task automatic go(input int d, input logic [12:0] a, input logic [12:0] b,
                      input logic c);
        @(negedge clk);
        a_in[d]  = a;
        b_in[d]  = b;
        cin[d]   = c;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        a_in[d]  = 13'($urandom);
        b_in[d]  = 13'($urandom);
        cin[d]   = 1'($urandom_range(0, 1));
        wait_idle(d);
    endtask

    task automatic expect_sum(input logic [13:0] v);
        dir_t r;
        r.kind = 0;
        r.exp  = v;
        dir_q.push_back(r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; a_in[d] = '0; b_in[d] = '0; cin[d] = 1'b0;
            rem[d] = 0; acc_cnt[d] = 0; done_cnt[d] = 0; last[d] = '0;
        end
        cyc = 0; n_checks = 0; n_errors = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        go(0, 13'h5A, 13'h3C, 1'b0);  expect_sum(14'h096);
        go(0, 13'hFF, 13'h01, 1'b0);  expect_sum(14'h100);
        go(0, 13'hFF, 13'hFF, 1'b1);  expect_sum(14'h1FF);

        // Start pulsed mid-operation with different operands is ignored.
        @(negedge clk);
        a_in[0] = 13'h01; b_in[0] = 13'h01; cin[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        a_in[0] = 13'h10; b_in[0] = 13'h10; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; a_in[0] = 13'h77; b_in[0] = 13'h55;
        wait_idle(0);
        expect_sum(14'h002);

        // Start held high: second operation accepted only back in IDLE.
        @(negedge clk);
        a_in[0] = 13'h03; b_in[0] = 13'h04; cin[0] = 1'b0; start[0] = 1'b1;
        repeat (wid(0) + 3) @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);
        expect_sum(14'h007);

        // Reset at the 4th SHIFT edge aborts the operation.
        go(0, 13'h5A, 13'h3C, 1'b0);
        @(negedge clk);
        a_in[0] = 13'h11; b_in[0] = 13'h22; cin[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        go(0, 13'h11, 13'h22, 1'b0);  expect_sum(14'h033);

        // Random regression on both widths concurrently.
        fork
            begin
                for (int i = 0; i < 1000; i++)
                    go(0, 13'($urandom), 13'($urandom), 1'($urandom_range(0, 1)));
            end
            begin
                for (int j = 0; j < 1000; j++)
                    go(1, 13'($urandom), 13'($urandom), 1'($urandom_range(0, 1)));
            end
        join

        begin
            dir_t r;
            r.kind = 1;
            r.exp  = '0;
            dir_q.push_back(r);
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder sequencer that drives a single one-bit full-adder cell over successive clock cycles to add two WIDTH-bit operands. It sits directly upstream of the full-adder cell: it latches operands, presents one bit pair plus the registered carry to the cell each cycle, and collects the cell's SUM/CARRY outputs into a result register. It trades latency for area against a ripple-carry array.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- A_IN  input  WIDTH  operand A; captured on the accepted start edge.
- B_IN  input  WIDTH  operand B; captured on the accepted start edge.
- CIN  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- SUM_OUT  output  WIDTH  result sum; holds the last completed result.
- COUT  output  1  result carry-out; holds the last completed result.

## Operation
- Internal registers: a_sh, b_sh (WIDTH), s_sh (WIDTH), carry (1), cnt ($clog2(WIDTH+1) bits), state.
- The full-adder cell inputs are a_sh[0], b_sh[0], carry. Its outputs are bit_sum and bit_carry; the cell is combinational.
- States:
  - IDLE
  - SHIFT
  - DONE
- IDLE:
  - start=1 loads a_sh<=A_IN, b_sh<=B_IN, carry<=CIN, cnt<=0, and moves to SHIFT.
  - start=0 holds all state.
- SHIFT, each edge:
  - a_sh, b_sh shift right by one (zero fill).
  - s_sh <= {bit_sum, s_sh[WIDTH-1:1]}.
  - carry <= bit_carry.
  - cnt <= cnt+1.
- SHIFT completion: on the edge where cnt == WIDTH-1, SUM_OUT <= {bit_sum, s_sh[WIDTH-1:1]}, COUT <= bit_carry, done <= 1, and the state moves to DONE.
- DONE: done <= 0 and the state moves to IDLE unconditionally. start is ignored in this state.
- start while busy=1 is ignored; there is no queueing.
- A_IN, B_IN and CIN changes after capture have no effect on the operation in progress.
- Arithmetic: {COUT, SUM_OUT} = A_IN + B_IN + CIN, modulo 2^(WIDTH+1). No overflow flag.
- SUM_OUT and COUT change only on completion or reset. Partial sums are never visible on the outputs.

## Timing
- Reset (rst_n=0, immediate, asynchronous) forces:
  - state=IDLE
  - busy=0
  - done=0
  - SUM_OUT=0
  - COUT=0
  - a_sh, b_sh, s_sh, carry, cnt = 0
- Reset mid-operation aborts the operation: no done pulse, and outputs return to 0.
- Release is synchronous to the first clk edge with rst_n=1.
- Accepted start at edge E0:
  - busy rises after E0.
  - WIDTH processing edges follow (E1..EWIDTH).
  - SUM_OUT, COUT and done update at EWIDTH.
  - done is high for exactly the cycle between EWIDTH and EWIDTH+1.
  - busy falls after EWIDTH+1.
- Latency: WIDTH edges from start to done. Throughput: one operation per WIDTH+2 cycles; the earliest next accepted start is at EWIDTH+2.
- busy and done are registered outputs. No combinational path from any input to any output.

## Test plan
- WIDTH=8, reset, then A_IN=0x5A, B_IN=0x3C, CIN=0, start for 1 cycle -> done pulses 8 edges after start, SUM_OUT=0x96, COUT=0, busy high for 9 cycles.
- A_IN=0xFF, B_IN=0x01, CIN=0 -> SUM_OUT=0x00, COUT=1. Then A_IN=0xFF, B_IN=0xFF, CIN=1 -> SUM_OUT=0xFF, COUT=1.
- Start 0x01+0x01. Then, while busy, pulse start with 0x10+0x10 and change A_IN/B_IN -> exactly one done, SUM_OUT=0x02. Start held high through DONE -> a new operation is accepted only at the IDLE edge.
- Complete 0x5A+0x3C, then start 0x11+0x22 and assert rst_n=0 at the 4th SHIFT edge -> outputs go to 0 immediately, no done pulse. After release, a new start of 0x11+0x22 gives SUM_OUT=0x33, COUT=0.
- Check previous-result hold: during the second operation SUM_OUT stays 0x96 until that operation's done edge.
- Random regression: 1000 random operands/CIN at WIDTH=8 and WIDTH=13 -> {COUT, SUM_OUT} matches the reference sum. done count equals accepted start count.
